// File: rtl/sram_access_sequencer.sv
// Splits one 32-bit load/store into two 16-bit SRAM accesses (low half first),
// holding ready low so the pipeline freezes until the word access completes.
module sram_access_sequencer #(
    parameter int unsigned WAIT_CYCLES = 3,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_in,
    output logic        sram_we_n,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {IDLE = 2'd0, LOW = 2'd1, HIGH = 2'd2, DONE = 2'd3} state_t;

    localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        op_wr;
    logic [16:0] idx;
    logic [31:0] wdata;
    logic [15:0] rd_lo;
    logic [17:0] addr_hold;
    logic [31:0] offset;
    logic        req, last, accept, in_phase;
    logic        unused_offset_bits;

    // Modulo-2^32 offset into data memory; byte-lane bits and upper bits are dropped.
    assign offset             = address - BASE_ADDR;
    assign unused_offset_bits = ^{offset[31:19], offset[1:0]};

    assign req       = wr_en | rd_en;
    assign last      = (cnt == LAST);
    assign accept    = (state == IDLE) && req;
    assign in_phase  = (state == LOW) || (state == HIGH);
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                cnt_nxt = 4'd0;
                if (req) state_nxt = LOW;
            end
            LOW: begin
                cnt_nxt = cnt + 4'd1;
                if (last) begin
                    state_nxt = HIGH;
                    cnt_nxt   = 4'd0;
                end
            end
            HIGH: begin
                cnt_nxt = cnt + 4'd1;
                if (last) begin
                    state_nxt = DONE;
                    cnt_nxt   = 4'd0;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Strobe is released on the last cycle of each phase so the address only moves while we_n is high.
    always_comb begin
        ready       = 1'b0;
        sram_addr   = addr_hold;
        sram_dq_out = 16'h0000;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        case (state)
            IDLE: ready = !req;
            LOW: begin
                sram_addr   = {idx, 1'b0};
                sram_dq_out = wdata[15:0];
                sram_dq_oe  = op_wr;
                sram_we_n   = !(op_wr && !last);
            end
            HIGH: begin
                sram_addr   = {idx, 1'b1};
                sram_dq_out = wdata[31:16];
                sram_dq_oe  = op_wr;
                sram_we_n   = !(op_wr && !last);
            end
            default: ready = 1'b1;
        endcase
    end

    // The low half is parked in rd_lo so read_data only ever changes to a complete word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_wr     <= 1'b0;
            idx       <= 17'd0;
            wdata     <= 32'h0;
            rd_lo     <= 16'h0;
            read_data <= 32'h0;
            addr_hold <= 18'd0;
        end else begin
            if (accept) begin
                op_wr <= wr_en;
                idx   <= offset[18:2];
                wdata <= write_data;
            end
            if (in_phase) addr_hold <= sram_addr;
            if (state == LOW && last && !op_wr) rd_lo <= sram_dq_in;
            if (state == HIGH && last && !op_wr) read_data <= {sram_dq_in, rd_lo};
        end
    end

endmodule

// File: tb/tb_sram_access_sequencer.sv
// Directed bench for sram_access_sequencer: a vector table of word accesses
// plus hand-written back-to-back and mid-access reset sequences.
module tb_sram_access_sequencer;

    localparam int W = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] address = 32'h0;
    logic [31:0] write_data = 32'h0;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        sram_we_n;
    logic [1:0]  state_dbg;

    int n_pass = 0;
    int n_total = 0;

    sram_access_sequencer #(.WAIT_CYCLES(W), .BASE_ADDR(32'd1024)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en),
        .address(address), .write_data(write_data), .read_data(read_data),
        .ready(ready), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
        .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // SRAM model: 256 half-words, aliased on the low address bits.
    logic [15:0] mem [0:255];
    logic        loaded = 1'b0;
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
            mem[4] <= 16'h5678;
            mem[5] <= 16'h1234;
            loaded <= 1'b1;
        end else if (!sram_we_n && sram_dq_oe) begin
            mem[sram_addr[7:0]] <= sram_dq_out;
        end
    end
    assign sram_dq_in = mem[sram_addr[7:0]];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [17:0] lo;
        logic [31:0] exp_rd;
    } vec_t;

    // One full access; requests are dropped after acceptance and must still complete.
    task automatic run_access(input vec_t v, input int n);
        logic        wr_eff;
        logic [17:0] ea;
        logic [15:0] ed;
        logic        eoe, ewe, erdy, phase;
        wr_eff = v.wr;
        @(negedge clk);
        wr_en = v.wr; rd_en = v.rd; address = v.addr; write_data = v.wdata;
        for (int c = 0; c <= 2 * W + 1; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 1) begin wr_en = 1'b0; rd_en = 1'b0; end
            #1;
            phase = (c >= 1) && (c <= 2 * W);
            erdy  = (c == 2 * W + 1);
            eoe   = wr_eff && phase;
            ewe   = !(wr_eff && phase && (((c - 1) % W) != W - 1));
            ea    = (c == 0) ? 18'd0 : (c <= W) ? v.lo : (v.lo | 18'd1);
            ed    = (!wr_eff || !phase) ? 16'h0 : (c <= W) ? v.wdata[15:0] : v.wdata[31:16];
            check($sformatf("vec%0d cyc%0d bus", n, c),
                  {29'd0, erdy, ewe, eoe, 14'd0, ea, ed},
                  {29'd0, ready, sram_we_n, sram_dq_oe, 14'd0,
                   (c == 0) ? 18'd0 : sram_addr,
                   (!wr_eff || !phase) ? 16'h0 : sram_dq_out});
        end
        check($sformatf("vec%0d done read_data", n), {32'd0, read_data}, {32'd0, v.exp_rd});
        @(negedge clk); #1;
        check($sformatf("vec%0d idle", n),
              {ready, sram_we_n, sram_dq_oe, sram_addr, read_data},
              {1'b1, 1'b1, 1'b0, v.lo | 18'd1, v.exp_rd});
    endtask

    vec_t vecs [7];

    initial begin
        int stalls, dones, first_done, cyc;
        logic rdy_after_done;

        vecs[0] = '{1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 18'd2, 32'h00000000};
        vecs[1] = '{1'b0, 1'b1, 32'd1032, 32'h0,        18'd4, 32'h12345678};
        vecs[2] = '{1'b0, 1'b1, 32'd1028, 32'h0,        18'd2, 32'hDEADBEEF};
        vecs[3] = '{1'b1, 1'b0, 32'd1027, 32'hCAFEF00D, 18'd0, 32'hDEADBEEF};
        vecs[4] = '{1'b0, 1'b1, 32'd1024, 32'h0,        18'd0, 32'hCAFEF00D};
        vecs[5] = '{1'b1, 1'b0, 32'd0,    32'h0BADC0DE, 18'h3FE00, 32'hCAFEF00D};
        vecs[6] = '{1'b1, 1'b1, 32'd1036, 32'h11223344, 18'd6, 32'hCAFEF00D};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        check("reset outputs",
              {ready, sram_we_n, sram_dq_oe, sram_addr, sram_dq_out, read_data},
              {1'b1, 1'b1, 1'b0, 18'd0, 16'h0, 32'h0});

        for (int i = 0; i < 7; i++) run_access(vecs[i], i);

        check("mem write low",  {mem[2], mem[3]}, {16'hBEEF, 16'hDEAD});
        check("mem both-high",  {mem[6], mem[7]}, {16'h3344, 16'h1122});

        // Back-to-back: request held across DONE.
        @(negedge clk);
        rd_en = 1'b1; address = 32'd1032;
        stalls = 0; dones = 0; first_done = -1; rdy_after_done = 1'b1;
        cyc = 0;
        while (dones < 2 && cyc < 40) begin
            #1;
            if (!ready) stalls++;
            if (cyc == first_done + 1 && first_done >= 0) rdy_after_done = ready;
            if (ready) begin
                dones++;
                if (dones == 1) first_done = cyc;
                else rd_en = 1'b0;
            end
            if (dones < 2) begin @(negedge clk); cyc++; end
        end
        rd_en = 1'b0;
        check("b2b completed",  dones, 2);
        check("b2b first done", first_done, 2 * W + 1);
        check("b2b idle gap ready", {63'd0, rdy_after_done}, 64'd0);
        check("b2b stalls",     stalls, 2 * (2 * W + 1));
        check("b2b read_data",  {32'd0, read_data}, {32'd0, 32'h12345678});

        // Reset in the middle of a write's HIGH phase.
        @(negedge clk);
        wr_en = 1'b1; address = 32'd1028; write_data = 32'hAAAA5555;
        repeat (W + 1) @(negedge clk);
        #1;
        check("pre-reset strobe", {sram_we_n, sram_addr}, {1'b0, 18'd3});
        rst_n = 1'b0;
        #1;
        check("async reset", {sram_we_n, sram_dq_oe, ready, read_data},
              {1'b1, 1'b0, 1'b0, 32'h0});
        wr_en = 1'b0;
        #1;
        check("reset idle", {ready, sram_addr, state_dbg}, {1'b1, 18'd0, 2'd0});
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("post reset", {ready, sram_we_n, read_data}, {1'b1, 1'b1, 32'h0});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
